scalar_preg_free_list: RTL

- Allocator for free physical scalar (integer) registers; sits between the rename stage (allocation) and commit (release).
- Circular buffer of free physical register numbers. Supports up to POP_WIDTH allocations and PUSH_WIDTH releases per cycle.
- After reset, a self-initialising FSM fills the buffer with every physical register not mapped to a logical register.

---
 rtl/scalar_preg_free_list.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/scalar_preg_free_list.sv
// rtl/scalar_preg_free_list.sv - circular free list of physical scalar register numbers
//
// Hands out free physical register numbers to rename (up to POP_WIDTH per cycle)
// and takes released numbers back from commit (up to PUSH_WIDTH per cycle).
// After reset an INIT phase writes INIT_BASE..INIT_BASE+ENTRY_NUM-1 into the list.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   popCount      registers requested this cycle (0..POP_WIDTH)
//   popGrant      all requested registers granted (combinational)
//   popData       lane k carries the entry at head+k (combinational)
//   pushEn        per-lane release valid, any pattern
//   pushData      released register numbers
//   ready         initialisation complete
//   freeCount     registered number of free entries
//   overflowErr   sticky: a release was dropped because the list was full
module scalar_preg_free_list #(
    parameter int ENTRY_NUM   = 32,
    parameter int ENTRY_WIDTH = 6,
    parameter int INIT_BASE   = 32,
    parameter int POP_WIDTH   = 2,
    parameter int PUSH_WIDTH  = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [$clog2(POP_WIDTH):0]              popCount,
    output logic                                    popGrant,
    output logic [POP_WIDTH-1:0][ENTRY_WIDTH-1:0]   popData,
    input  logic [PUSH_WIDTH-1:0]                   pushEn,
    input  logic [PUSH_WIDTH-1:0][ENTRY_WIDTH-1:0]  pushData,
    output logic                                    ready,
    output logic [$clog2(ENTRY_NUM):0]              freeCount,
    output logic                                    overflowErr
);
    localparam int PTR_W = $clog2(ENTRY_NUM);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {S_INIT, S_RUN} state_e;

    state_e                 state_q, state_d;
    logic [PTR_W-1:0]       init_idx_q, init_idx_d;
    logic [PTR_W-1:0]       head_q, head_d;
    logic [PTR_W-1:0]       tail_q, tail_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   ovf_q, ovf_d;

    logic [ENTRY_WIDTH-1:0] mem [ENTRY_NUM];

    // Write ports into mem; lane 0 is also borrowed by the INIT fill.
    logic [PUSH_WIDTH-1:0]  wr_en;
    logic [PTR_W-1:0]       wr_addr [PUSH_WIDTH];
    logic [ENTRY_WIDTH-1:0] wr_data [PUSH_WIDTH];

    logic [CNT_W-1:0]       pop_req;
    logic [CNT_W-1:0]       pop_n;
    logic [CNT_W-1:0]       push_n;
    logic [CNT_W-1:0]       space;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        popGrant   = 1'b0;
        popData    = '0;
        wr_en      = '0;
        pop_req    = CNT_W'(popCount);
        pop_n      = '0;
        push_n     = '0;
        space      = '0;
        for (int j = 0; j < PUSH_WIDTH; j++) begin
            wr_addr[j] = '0;
            wr_data[j] = '0;
        end

        // While rst is high nothing is granted or written; the flops reset anyway.
        if (!rst) begin
            unique case (state_q)
                S_INIT: begin
                    wr_en[0]   = 1'b1;
                    wr_addr[0] = init_idx_q;
                    wr_data[0] = ENTRY_WIDTH'(INIT_BASE) + ENTRY_WIDTH'(init_idx_q);
                    init_idx_d = init_idx_q + 1'b1;
                    if (init_idx_q == PTR_W'(ENTRY_NUM - 1)) begin
                        state_d = S_RUN;
                        head_d  = '0;
                        tail_d  = '0;
                        count_d = CNT_W'(ENTRY_NUM);
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < POP_WIDTH; k++) begin
                        popData[k] = mem[head_q + PTR_W'(k)];
                    end
                    // All-or-nothing grant: a short list stalls rename entirely.
                    popGrant = (popCount != '0) && (pop_req <= count_q);
                    if (popGrant) begin
                        pop_n = pop_req;
                    end
                    // Slots freed by this cycle's pops are reusable by this cycle's pushes.
                    space = CNT_W'(ENTRY_NUM) - count_q + pop_n;
                    // Compact set lanes in lane order; once space runs out the
                    // remaining (higher) lanes are dropped.
                    for (int j = 0; j < PUSH_WIDTH; j++) begin
                        if (pushEn[j]) begin
                            if (push_n < space) begin
                                wr_en[j]   = 1'b1;
                                wr_addr[j] = tail_q + PTR_W'(push_n);
                                wr_data[j] = pushData[j];
                                push_n     = push_n + 1'b1;
                            end else begin
                                ovf_d = 1'b1;
                            end
                        end
                    end
                    head_d  = head_q + PTR_W'(pop_n);
                    tail_d  = tail_q + PTR_W'(push_n);
                    count_d = count_q - pop_n + push_n;
                end
                default: state_d = S_INIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_idx_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage is not reset; INIT rewrites every entry before it can be read.
    always_ff @(posedge clk) begin
        for (int j = 0; j < PUSH_WIDTH; j++) begin
            if (wr_en[j]) begin
                mem[wr_addr[j]] <= wr_data[j];
            end
        end
    end

    assign ready       = (state_q == S_RUN);
    assign freeCount   = count_q;
    assign overflowErr = ovf_q;
endmodule
